// File: rtl/ksa_share_arb.sv
`default_nettype none
// ============================================================================
//  Module   : ksa_share_arb (with ksa_top_16b)
//  Brief    : Round-robin arbiter sharing one 16-bit Kogge-Stone adder among
//             N_REQ requesters, with a single registered, tagged result slot.
//  Revision : 1.0 - initial release
// ============================================================================

module ksa_top_16b (
    input  logic        c0,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] s,
    output logic        c32
);
    logic [16:0] w_c;

    // Level 0 holds bitwise generate/propagate; each later level doubles the span.
    for (genvar l = 0; l < 5; l++) begin : g_lvl
        logic [15:0] gg;
        logic [15:0] pp;
        if (l == 0) begin : g_base
            assign gg = a & b;
            assign pp = a ^ b;
        end else begin : g_pref
            for (genvar i = 0; i < 16; i++) begin : g_bit
                if (i >= (1 << (l - 1))) begin : g_comb
                    assign gg[i] = g_lvl[l-1].gg[i] |
                                   (g_lvl[l-1].pp[i] & g_lvl[l-1].gg[i-(1<<(l-1))]);
                    assign pp[i] = g_lvl[l-1].pp[i] & g_lvl[l-1].pp[i-(1<<(l-1))];
                end else begin : g_pass
                    assign gg[i] = g_lvl[l-1].gg[i];
                    assign pp[i] = g_lvl[l-1].pp[i];
                end
            end
        end
    end

    assign w_c = {g_lvl[4].gg | (g_lvl[4].pp & {16{c0}}), c0};
    assign s   = g_lvl[0].pp ^ w_c[15:0];
    assign c32 = w_c[16];
endmodule

module ksa_share_arb #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req_valid,
    output logic [N_REQ-1:0]  req_ready,
    input  logic [16*N_REQ-1:0] req_a,
    input  logic [16*N_REQ-1:0] req_b,
    input  logic [N_REQ-1:0]  req_cin,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ID_W-1:0]   rsp_id,
    output logic [15:0]       rsp_sum,
    output logic              rsp_cout,
    output logic              rsp_ovf,
    output logic [7:0]        busy_cnt
);
    localparam logic [ID_W-1:0] c_LAST = ID_W'(N_REQ - 1);
    localparam logic [ID_W:0]   c_NREQ = (ID_W+1)'(N_REQ);

    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  w_idx;
    logic [ID_W:0]    w_j;
    logic             w_found;
    logic             w_slot_free;
    logic             w_xfer;
    logic             w_stall;
    logic [N_REQ-1:0] w_onehot;
    logic [15:0]      w_a;
    logic [15:0]      w_b;
    logic             w_cin;
    logic [15:0]      w_s;
    logic             w_c32;
    logic             w_ovf;

    assign w_slot_free = !rsp_valid || rsp_ready;

    // Search upward from the pointer, wrapping at N_REQ.
    always_comb begin
        w_found  = 1'b0;
        w_idx    = '0;
        w_j      = '0;
        w_onehot = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_j = {1'b0, r_ptr} + (ID_W+1)'(k);
            if (w_j >= c_NREQ) w_j = w_j - c_NREQ;
            if (!w_found && req_valid[w_j[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_idx   = w_j[ID_W-1:0];
            end
        end
        if (w_found) w_onehot[w_idx] = 1'b1;
    end

    assign req_ready = (w_slot_free && !rst) ? w_onehot : '0;
    assign w_xfer    = |(req_valid & req_ready);
    assign w_stall   = |(req_valid & ~req_ready);

    assign w_a   = req_a[16*w_idx +: 16];
    assign w_b   = req_b[16*w_idx +: 16];
    assign w_cin = req_cin[w_idx];

    ksa_top_16b u_ksa (
        .c0  (w_cin),
        .a   (w_a),
        .b   (w_b),
        .s   (w_s),
        .c32 (w_c32)
    );

    assign w_ovf = (w_a[15] == w_b[15]) && (w_s[15] != w_a[15]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_ovf   <= 1'b0;
            busy_cnt  <= '0;
        end else begin
            if (w_xfer) begin
                rsp_valid <= 1'b1;
                rsp_id    <= w_idx;
                rsp_sum   <= w_s;
                rsp_cout  <= w_c32;
                rsp_ovf   <= w_ovf;
                r_ptr     <= (w_idx == c_LAST) ? '0 : w_idx + 1'b1;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            if (w_stall && busy_cnt != 8'hFF) busy_cnt <= busy_cnt + 8'd1;
        end
    end
endmodule

`default_nettype wire

// File: doc/ksa_share_arb.md
Name: ksa_share_arb

Overview:
- Round-robin arbiter that time-shares one ksa_top_16b instance (port order c0, a, b, s, c32) between N_REQ butterfly/twiddle requesters in the 64-point FFT datapath.
- Accepts at most one add per cycle and registers the adder result into a single output slot.
- The response is tagged with the requester index. Response-side backpressure is supported.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of rsp_id; must equal ceil(log2(N_REQ)).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  N_REQ  per-requester operation valid.
- req_ready  output  N_REQ  per-requester accept (one-hot or zero).
- req_a  input  16*N_REQ  operand A; requester i uses bits [16i+15:16i].
- req_b  input  16*N_REQ  operand B, same packing.
- req_cin  input  N_REQ  carry-in per requester.
- rsp_valid  output  1  result slot full.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  ID_W  index of requester that issued the result.
- rsp_sum  output  16  sum[15:0].
- rsp_cout  output  1  carry out of bit 15 (unsigned overflow).
- rsp_ovf  output  1  signed overflow: a[15]==b[15] and sum[15]!=a[15].
- busy_cnt  output  8  saturating count of cycles in which a requester was valid but not granted (stall statistic).

Behaviour:
- Reset (asynchronous, takes effect immediately, any cycle):
  - rsp_valid=0; rsp_id, rsp_sum, rsp_cout, rsp_ovf = 0; busy_cnt=0.
  - Priority pointer = 0, so requester 0 has highest priority.
  - req_ready is combinational and therefore 0 while rst=1.
- Slot free: slot_free = !rsp_valid || rsp_ready (combinational).
- Grant:
  - When slot_free=1, the first requester with req_valid=1 is granted, searching from pointer upward modulo N_REQ.
  - req_ready is one-hot on the granted index and 0 elsewhere.
  - When slot_free=0, all req_ready are 0.
  - req_ready may depend combinationally on req_valid and rsp_ready; it must not depend on req_a, req_b or req_cin.
- Transfer: occurs for requester i when req_valid[i] && req_ready[i].
- Datapath:
  - The granted operands/cin are muxed into the single adder instance.
  - On a transfer, at the next rising edge: slot <= {granted id, s, c32, ovf}, and rsp_valid <= 1.
  - Latency is exactly 1 cycle from transfer to rsp_valid.
- Pointer update: on a transfer from index g, pointer <= (g+1) mod N_REQ. With no transfer, pointer is unchanged.
- Drain: if rsp_valid && rsp_ready and there is no new transfer in the same cycle, rsp_valid <= 0.
- Simultaneous drain and accept: the slot is overwritten with the new result and rsp_valid stays 1. This gives full throughput of 1 result per cycle.
- Backpressure: while rsp_valid && !rsp_ready, all rsp_* outputs hold stable and no grant is issued.
- Requester obligations: a requester holding req_valid must keep operands stable until its transfer. The arbiter does not check this.
- busy_cnt:
  - Increments by 1 for each cycle where any bit of (req_valid & ~req_ready) is set.
  - Saturates at 255; no wrap.
- Fairness: with all requesters continuously valid and rsp_ready=1, grants rotate 0,1,2,3,0,... Worst-case wait is N_REQ-1 grants.
- Arithmetic: {rsp_cout, rsp_sum} = a + b + cin as 17-bit unsigned. Full range holds: FFFF+FFFF+1 = 1_FFFF.
- Mid-operation reset: a pending result is discarded; after reset is released, the first grant goes to the lowest-indexed valid requester.
- Structure: purely synchronous except the reset. Single clock domain; no internal FIFOs beyond the one slot.

Test Plan:
- Reset, then only req 2 valid with a=0x1234, b=0x0001, cin=1, rsp_ready=1 -> req_ready=0100; next cycle rsp_valid=1, id=2, sum=0x1236, cout=0, ovf=0.
- Req 1 valid with a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1, ovf=0. Req 0 valid with a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
- All 4 valid continuously, rsp_ready=1, 8 cycles -> rsp_id sequence 0,1,2,3,0,1,2,3 on back-to-back cycles; busy_cnt increments each cycle.
- Result pending, rsp_ready=0 held for 5 cycles with req 3 valid -> req_ready=0 throughout, rsp_* stable. Raise rsp_ready -> req 3 granted that same cycle, its result appears next cycle, rsp_valid never drops.
- Req 0 and req 1 both valid continuously, rsp_ready=0 for 300 cycles -> busy_cnt saturates at 255 and holds.
- Assert rst mid-burst with rsp_valid=1 -> rsp_valid=0 immediately (asynchronous). After release with reqs 1 and 3 valid -> first grant to 1, then 3.
